// File: rtl/game_ctrl_if.sv
// Signal bundle between game_ctrl and its neighbours (debouncers, pipe logic, renderer).
interface game_ctrl_if;
   logic        frame_tick;
   logic        flap;
   logic        pause;
   logic        collide;
   logic        pipe_passed;
   logic [9:0]  bird_y;
   logic [1:0]  state;
   logic [15:0] score_bcd;
   logic        scroll_en;
   logic        dead;

   modport master (
      output frame_tick, flap, pause, collide, pipe_passed,
      input  bird_y, state, score_bcd, scroll_en, dead
   );

   modport slave (
      input  frame_tick, flap, pause, collide, pipe_passed,
      output bird_y, state, score_bcd, scroll_en, dead
   );
endinterface

// File: rtl/game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/PAUSE/DEAD FSM, bird vertical physics
// and saturating 4-digit BCD score.
module game_ctrl #(
   parameter int unsigned Y_START      = 240,
   parameter int unsigned Y_MAX        = 470,
   parameter int unsigned GRAVITY      = 1,
   parameter int unsigned FLAP_IMPULSE = 8,
   parameter int unsigned V_MAX        = 10
) (
   input logic        clk,
   input logic        clr_n,
   game_ctrl_if.slave gc
);

   localparam int unsigned YW = 10;
   localparam int unsigned VW = 8;
   localparam int unsigned SW = 16;

   localparam logic signed [VW-1:0] VEL_FLAP = VW'(-$signed(VW'(FLAP_IMPULSE)));
   localparam logic signed [VW:0]   VEL_MAX  = $signed((VW+1)'(V_MAX));
   localparam logic signed [VW:0]   VEL_GRAV = $signed((VW+1)'(GRAVITY));
   localparam logic signed [YW:0]   Y_FLOOR  = $signed((YW+1)'(Y_MAX));

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DEAD  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [YW-1:0]         bird_y_q, bird_y_d;
   logic signed [VW-1:0]  vel_q, vel_d;
   logic [SW-1:0]         score_q, score_d;
   logic                  flap_pend_q, flap_pend_d;
   logic                  flap_q, pause_q;
   logic                  scroll_en_q, dead_q;

   logic                  flap_rise, pause_rise;
   logic signed [YW:0]    y_next;
   logic signed [VW:0]    v_inc;

   assign flap_rise  = gc.flap  & ~flap_q;
   assign pause_rise = gc.pause & ~pause_q;
   assign y_next     = $signed({1'b0, bird_y_q}) + (YW+1)'(vel_q);
   assign v_inc      = (VW+1)'(vel_q) + VEL_GRAV;

   // Saturating BCD increment with per-digit carry
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      logic          carry;
      r     = s;
      carry = 1'b1;
      if (s != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= ST_IDLE;
         bird_y_q    <= YW'(Y_START);
         vel_q       <= '0;
         score_q     <= '0;
         flap_pend_q <= 1'b0;
         flap_q      <= 1'b1;
         pause_q     <= 1'b1;
         scroll_en_q <= 1'b0;
         dead_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bird_y_q    <= bird_y_d;
         vel_q       <= vel_d;
         score_q     <= score_d;
         flap_pend_q <= flap_pend_d;
         flap_q      <= gc.flap;
         pause_q     <= gc.pause;
         scroll_en_q <= (state_d == ST_PLAY);
         dead_q      <= (state_d == ST_DEAD);
      end
   end

   always_comb begin
      state_d     = state_q;
      bird_y_d    = bird_y_q;
      vel_d       = vel_q;
      score_d     = score_q;
      flap_pend_d = flap_pend_q;

      unique case (state_q)
         ST_IDLE: begin
            bird_y_d = YW'(Y_START);
            vel_d    = '0;
            if (flap_rise) begin
               state_d     = ST_PLAY;
               score_d     = '0;
               flap_pend_d = 1'b1;
            end
         end

         ST_PLAY: begin
            if (flap_rise) flap_pend_d = 1'b1;
            if (gc.frame_tick) begin
               if (y_next[YW]) begin
                  bird_y_d = '0;
               end else if (y_next >= Y_FLOOR) begin
                  bird_y_d = YW'(Y_MAX);
                  state_d  = ST_DEAD;
               end else begin
                  bird_y_d = y_next[YW-1:0];
               end
               // A flap pressed on the tick cycle itself still takes effect
               if (flap_pend_q || flap_rise) begin
                  vel_d       = VEL_FLAP;
                  flap_pend_d = 1'b0;
               end else if (v_inc > VEL_MAX) begin
                  vel_d = VEL_MAX[VW-1:0];
               end else begin
                  vel_d = v_inc[VW-1:0];
               end
            end
            if (gc.pipe_passed) score_d = bcd_inc(score_q);
            if (gc.collide) begin
               state_d = ST_DEAD;
            end else if (pause_rise && (state_d != ST_DEAD)) begin
               state_d = ST_PAUSE;
            end
         end

         ST_PAUSE: begin
            flap_pend_d = 1'b0;
            if (pause_rise) state_d = ST_PLAY;
         end

         ST_DEAD: begin
            if (flap_rise) begin
               state_d     = ST_IDLE;
               bird_y_d    = YW'(Y_START);
               vel_d       = '0;
               flap_pend_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign gc.bird_y    = bird_y_q;
   assign gc.state     = state_q;
   assign gc.score_bcd = score_q;
   assign gc.scroll_en = scroll_en_q;
   assign gc.dead      = dead_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl.
`timescale 1ns/1ps
module tb_game_ctrl;

   logic clk;
   logic clr_n;
   int   n_chk;
   int   n_bad;

   game_ctrl_if gif();

   game_ctrl dut (
      .clk   (clk),
      .clr_n (clr_n),
      .gc    (gif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      gif.frame_tick = 1'b1;
      step();
      gif.frame_tick = 1'b0;
   endtask

   task automatic press_flap();
      gif.flap = 1'b0;
      step();
      gif.flap = 1'b1;
      step();
      gif.flap = 1'b0;
   endtask

   task automatic press_pause();
      gif.pause = 1'b0;
      step();
      gif.pause = 1'b1;
      step();
      gif.pause = 1'b0;
   endtask

   task automatic pipe();
      gif.pipe_passed = 1'b1;
      step();
      gif.pipe_passed = 1'b0;
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int y, v, yn, prev_y;
      bit fell;
      n_chk = 0;
      n_bad = 0;
      gif.frame_tick  = 1'b0;
      gif.flap        = 1'b1;
      gif.pause       = 1'b0;
      gif.collide     = 1'b0;
      gif.pipe_passed = 1'b0;
      clr_n = 1'b0;
      #23;
      chk("rst_state", 32'(gif.state), 0);
      chk("rst_y", 32'(gif.bird_y), 240);
      chk("rst_score", 32'(gif.score_bcd), 0);
      chk("rst_scroll", 32'(gif.scroll_en), 0);
      chk("rst_dead", 32'(gif.dead), 0);

      // Flap held across reset release: no edge
      @(negedge clk) clr_n = 1'b1;
      repeat (3) step();
      chk("held_flap_state", 32'(gif.state), 0);
      chk("held_flap_y", 32'(gif.bird_y), 240);

      press_flap();
      chk("start_state", 32'(gif.state), 1);
      chk("start_scroll", 32'(gif.scroll_en), 1);
      chk("start_dead", 32'(gif.dead), 0);
      tick(); chk("tick1_y", 32'(gif.bird_y), 240);
      tick(); chk("tick2_y", 32'(gif.bird_y), 232);
      tick(); chk("tick3_y", 32'(gif.bird_y), 225);
      tick(); chk("tick4_y", 32'(gif.bird_y), 219);

      // Pause freezes physics and score
      press_pause();
      chk("pause_state", 32'(gif.state), 2);
      chk("pause_scroll", 32'(gif.scroll_en), 0);
      repeat (5) tick();
      pipe();
      chk("pause_y", 32'(gif.bird_y), 219);
      chk("pause_score", 32'(gif.score_bcd), 0);
      press_pause();
      chk("resume_state", 32'(gif.state), 1);

      // Score BCD carry through to saturation
      for (int i = 1; i <= 9999; i++) begin
         pipe();
         chk($sformatf("score_%0d", i), 32'(gif.score_bcd), 32'(to_bcd(i)));
      end
      pipe();
      chk("score_sat", 32'(gif.score_bcd), 32'h9999);
      chk("score_play_state", 32'(gif.state), 1);

      // Free fall to the floor (vel resumes at -5)
      y = 219; v = -5; fell = 1'b0; prev_y = y;
      for (int n = 0; n < 100 && !fell; n++) begin
         prev_y = y;
         yn = y + v;
         if (yn >= 470) begin y = 470; fell = 1'b1; end
         else if (yn < 0) y = 0;
         else y = yn;
         v = (v + 1 > 10) ? 10 : v + 1;
         tick();
         chk($sformatf("fall_y_%0d", n), 32'(gif.bird_y), 32'(y));
      end
      chk("fall_reached", 32'(fell), 1);
      chk("fall_prev_y", 32'(prev_y), 469);
      chk("floor_state", 32'(gif.state), 3);
      chk("floor_dead", 32'(gif.dead), 1);
      chk("floor_scroll", 32'(gif.scroll_en), 0);
      tick();
      chk("floor_hold_y", 32'(gif.bird_y), 470);
      pipe();
      chk("dead_score", 32'(gif.score_bcd), 32'h9999);
      press_pause();
      chk("dead_pause", 32'(gif.state), 3);

      press_flap();
      chk("restart_state", 32'(gif.state), 0);
      chk("restart_y", 32'(gif.bird_y), 240);
      chk("restart_score", 32'(gif.score_bcd), 32'h9999);
      chk("restart_dead", 32'(gif.dead), 0);
      tick();
      chk("idle_tick_y", 32'(gif.bird_y), 240);
      press_flap();
      chk("replay_state", 32'(gif.state), 1);
      chk("replay_score", 32'(gif.score_bcd), 0);

      // pipe_passed and collide together
      gif.pipe_passed = 1'b1;
      gif.collide     = 1'b1;
      step();
      gif.pipe_passed = 1'b0;
      gif.collide     = 1'b0;
      chk("pc_score", 32'(gif.score_bcd), 1);
      chk("pc_state", 32'(gif.state), 3);

      press_flap();
      press_flap();
      chk("replay2_state", 32'(gif.state), 1);

      // collide wins over pause_rise
      gif.pause = 1'b0;
      step();
      gif.pause   = 1'b1;
      gif.collide = 1'b1;
      step();
      gif.pause   = 1'b0;
      gif.collide = 1'b0;
      chk("cp_state", 32'(gif.state), 3);

      // Asynchronous reset mid-game
      press_flap();
      press_flap();
      pipe();
      tick();
      chk("pre_rst_state", 32'(gif.state), 1);
      chk("pre_rst_score", 32'(gif.score_bcd), 1);
      #2 clr_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(gif.state), 0);
      chk("async_rst_y", 32'(gif.bird_y), 240);
      chk("async_rst_score", 32'(gif.score_bcd), 0);
      chk("async_rst_scroll", 32'(gif.scroll_en), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game sequencer for Flappy Bird. It runs the IDLE/PLAY/PAUSE/DEAD state machine and owns the bird vertical physics (position, velocity, gravity, flap impulse). It keeps the BCD score for segdisplay and enables pipe scrolling. It sits between the debouncers, the pipe/collision logic and the VGA renderer. All inputs are already synchronous to clk.

Parameters:
Y_START, 240, bird y (pixels, top = 0) in IDLE and after reset
Y_MAX, 470, floor row; reaching or passing it is death
GRAVITY, 1, velocity increment per frame (pixels/frame)
FLAP_IMPULSE, 8, upward velocity magnitude applied on flap
V_MAX, 10, downward terminal velocity

Ports:
clk  in  1  system clock (100 MHz)
clr_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse, once per video frame
flap  in  1  debounced flap button level
pause  in  1  debounced pause button level
collide  in  1  level from pipe logic: bird overlaps a pipe
pipe_passed  in  1  one-cycle pulse: bird cleared a pipe
bird_y  out  10  bird top row, unsigned
state  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD
score_bcd  out  16  4-digit BCD score, [15:12] thousands
scroll_en  out  1  high only in PLAY
dead  out  1  high only in DEAD

Behaviour:
- Async reset (clr_n low): state=IDLE, bird_y=Y_START, vel=0, score_bcd=0, flap_pend=0, scroll_en=0, dead=0. flap_q and pause_q reset to 1, so a button held through reset produces no edge.
- Edge detect: flap_rise = flap & ~flap_q. pause_rise = pause & ~pause_q. flap_q and pause_q register every cycle. All registered responses appear on the clock edge after the rise cycle (1-cycle latency).
- vel is internal signed 8-bit; negative means upward.
- IDLE:
  - bird_y is held at Y_START and vel at 0.
  - flap_rise -> PLAY; score_bcd cleared to 0; flap_pend set.
  - score_bcd holds its last value in IDLE until that transition.
- PLAY:
  - flap_rise sets flap_pend.
  - On frame_tick: y_next = bird_y + vel (using vel before the update), computed 11-bit signed.
  - If y_next < 0: bird_y = 0, no death. Else bird_y = y_next.
  - If y_next >= Y_MAX: bird_y = Y_MAX and state -> DEAD.
  - Velocity update on the same tick: if flap_pend (or flap_rise in that same cycle), vel = -FLAP_IMPULSE and flap_pend cleared. Otherwise vel = min(vel+GRAVITY, V_MAX).
  - collide high in any cycle -> DEAD next cycle. Priority: collide/floor > pause_rise.
  - pipe_passed increments score_bcd with per-digit BCD carry; saturates at 9999.
  - If pipe_passed and collide occur in the same cycle, the score increments and state goes to DEAD.
  - pause_rise (without death) -> PAUSE.
- PAUSE:
  - frame_tick, collide, pipe_passed and flap are ignored; flap_pend is cleared.
  - bird_y, vel and score are frozen.
  - pause_rise -> PLAY.
- DEAD:
  - bird_y, vel and score are frozen; pipe_passed is ignored.
  - flap_rise -> IDLE: bird_y = Y_START, vel = 0.
  - pause is ignored.
- Outputs: scroll_en = (state==PLAY) and dead = (state==DEAD), both registered/decoded from the state register with no extra latency.
- Reset mid-game returns everything to reset values immediately and asynchronously.

Test Plan:
- Reset, then hold flap high across clr_n release -> no transition; state=0, bird_y=240, score_bcd=0x0000.
- In IDLE, flap rise -> next cycle state=1, scroll_en=1. Three frame_ticks follow.
  - bird_y after ticks: 240, 232, 225.
  - internal vel after ticks: -8, -7, -6.
- From PLAY with no flaps, apply frame_ticks until the floor:
  - vel saturates at 10.
  - bird_y clamps to 470.
  - state=3, dead=1, scroll_en=0.
  - A further frame_tick leaves bird_y at 470.
- pause rise in PLAY -> state=2. Then 5 frame_ticks plus a pipe_passed pulse -> bird_y, score unchanged. A second pause rise -> state=1.
- Score carry and saturation:
  - score 0x0009 + pipe_passed -> 0x0010.
  - 0x0999 -> 0x1000.
  - 0x9999 + pipe_passed -> stays 0x9999.
- Simultaneous events in PLAY:
  - collide + pause_rise in the same cycle -> state=3 (not 2).
  - pipe_passed + collide -> score increments and state=3.
  - In DEAD, flap rise -> state=0 with bird_y=240 and score retained; the next flap rise clears the score to 0.
